scoreboard_ctrl: RTL and testbench
==================================

Name: scoreboard_ctrl

Overview:
Game-sequencing controller that sits between the raw front-panel buttons and the scoreboard datapath (two score adders, the game timer and the ASCII converters). It turns button levels into single-cycle command pulses and gates scoring by game state. It drives the timer's pause input and detects period and game expiry from the timer's min/sec/period values. It raises a timed buzzer at each expiry.

Parameters:
NUM_PERIODS, 4, number of periods in a game; expiry while period==NUM_PERIODS ends the game
BUZZ_CYCLES, 50000000, buzzer-high duration in clk cycles (must be >=1; counter width = clog2(BUZZ_CYCLES+1))
W, 11, width of min/sec/period inputs (matches datapath score/time width)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_btn  in  1  raw start/resume button level
pause_btn  in  1  raw pause-toggle button level
btn_H  in  6  raw home buttons {minus3,minus2,minus1,plus3,plus2,plus1}
btn_G  in  6  raw guest buttons, same bit order
min  in  W  timer minutes
sec  in  W  timer seconds
period  in  W  timer period number (1-based)
pause  out  1  to timer pause input; 1 = timer frozen
cmd_H  out  6  one-cycle pulses to HOME adder, same bit order as btn_H
cmd_G  out  6  one-cycle pulses to GUEST adder
game_state  out  3  0 IDLE, 1 RUN, 2 PAUSED, 3 BREAK, 4 FINAL
buzzer  out  1  buzzer drive

Behaviour:
- Reset (sampled at a clk edge): state=IDLE, pause=1, cmd_H=cmd_G=0, buzzer=0, buzz counter=0, armed=0. Edge-detect history registers load the current button levels during reset, so a button held through reset does not fire.
- Edge detect: edge = level & ~prev, prev <= level every cycle. All outputs are registered. A rising level first sampled at edge n gives its effect (pulse or state change) visible after edge n+1. Each pulse lasts exactly 1 cycle. Holding a button produces no repeats.
- FSM (evaluated on detected edges):
  - IDLE: start edge -> RUN. Pause edge is ignored. If start and pause edges coincide, start wins.
  - RUN: expiry -> BREAK if period<NUM_PERIODS, else FINAL. Otherwise a pause edge -> PAUSED. Expiry has priority over a simultaneous pause edge.
  - PAUSED: pause edge or start edge -> RUN.
  - BREAK: start edge -> RUN.
  - FINAL: terminal; only reset leaves it.
- pause output = 0 only in RUN, 1 in all other states. It is registered together with the state.
- Expiry = armed & (min==0) & (sec==0) while in RUN.
  - armed is cleared on entry to RUN.
  - armed is set on the first RUN cycle where {min,sec} != 0.
  - This prevents a stale 0:00 from re-triggering when resuming from BREAK before the timer reloads.
- Scoring is enabled in RUN, PAUSED and BREAK, and disabled in IDLE and FINAL. Edges arriving while disabled are discarded; there is no queueing.
- Per-team arbitration: at most one cmd bit per team per cycle.
  - If several edges coincide for one team, forward the highest priority: plus3 > plus2 > plus1 > minus1 > minus2 > minus3. Drop the others.
  - Home and guest are independent; both may pulse in the same cycle.
- Scoring is evaluated using the state before this cycle's transition. An edge on the same cycle as RUN->FINAL is still forwarded.
- Buzzer: on each transition into BREAK or FINAL, buzzer=1 for exactly BUZZ_CYCLES cycles, then 0.
  - A new expiry while the buzzer is sounding reloads the counter.
  - Reset mid-buzz clears the buzzer immediately.
- Score saturation and negative clamping are the adders' job; this block only issues pulses.

Test Plan:
- Reset with btn_H[0] held high -> no cmd_H pulse after reset release. Release and re-press btn_H[0] in RUN -> cmd_H=6'b000001 for exactly 1 cycle, 1 cycle after the sample; held level gives no repeat.
- IDLE, btn_G[2] rises -> cmd_G stays 0. Start edge -> game_state=1 and pause=0 on the next cycle. Pause edge -> game_state=2, pause=1. Start edge -> back to RUN.
- RUN, btn_H={minus3,plus1,plus3} rising in the same cycle -> cmd_H=6'b000100 only. Simultaneous btn_G plus2 -> cmd_G=6'b000010 in the same cycle.
- RUN, period=1, min/sec count 0:01 -> 0:00 -> game_state=3, pause=1, buzzer high for exactly BUZZ_CYCLES (sim with 8). Start edge with timer still at 0:00 -> stays RUN (not armed); after the timer shows 10:00 and later reaches 0:00, -> BREAK again.
- period=NUM_PERIODS, 0:00 reached with a pause edge on the same cycle -> FINAL (not PAUSED), buzzer pulses. Later score and start edges -> no cmd pulses, state stays 4.
- Reset asserted mid-buzz in FINAL -> next cycle buzzer=0, game_state=0, pause=1.

Source files
------------

// File: rtl/scoreboard_ctrl.sv
// Game-sequencing controller for the scoreboard: button edges become one-cycle
// scoring commands, and the game state follows the start/pause buttons and timer expiry.
module scoreboard_ctrl #(
    parameter int NUM_PERIODS = 4,
    parameter int BUZZ_CYCLES = 50000000,
    parameter int W           = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_btn,
    input  logic         pause_btn,
    input  logic [5:0]   btn_H,
    input  logic [5:0]   btn_G,
    input  logic [W-1:0] min,
    input  logic [W-1:0] sec,
    input  logic [W-1:0] period,
    output logic         pause,
    output logic [5:0]   cmd_H,
    output logic [5:0]   cmd_G,
    output logic [2:0]   game_state,
    output logic         buzzer
);
    localparam int CW = $clog2(BUZZ_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_PAUSED = 3'd2,
        S_BREAK  = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    state_t        state, next_state;
    logic [13:0]   btn_lvl, lvl_q, prev_q, edges;
    logic          start_edge, pause_edge;
    logic [5:0]    h_edge, g_edge;
    logic          armed, time_zero, expiry;
    logic          score_en, enter_run, enter_buzz;
    logic [5:0]    cmd_h_next, cmd_g_next;
    logic [CW-1:0] buzz_cnt, buzz_cnt_next;

    // Levels are registered once, then edge-detected against the previous sample;
    // during reset both stages load the live level so a held button never fires.
    assign btn_lvl = {start_btn, pause_btn, btn_H, btn_G};

    always_ff @(posedge clk) begin
        lvl_q <= btn_lvl;
        if (reset) prev_q <= btn_lvl;
        else       prev_q <= lvl_q;
    end

    assign edges      = lvl_q & ~prev_q;
    assign start_edge = edges[13];
    assign pause_edge = edges[12];
    assign h_edge     = edges[11:6];
    assign g_edge     = edges[5:0];

    // One command per team per cycle: plus3 > plus2 > plus1 > minus1 > minus2 > minus3.
    function automatic logic [5:0] pick(input logic [5:0] e);
        logic [5:0] r;
        r = 6'b000000;
        if      (e[2]) r = 6'b000100;
        else if (e[1]) r = 6'b000010;
        else if (e[0]) r = 6'b000001;
        else if (e[3]) r = 6'b001000;
        else if (e[4]) r = 6'b010000;
        else if (e[5]) r = 6'b100000;
        return r;
    endfunction

    assign time_zero = (min == '0) && (sec == '0);
    assign expiry    = (state == S_RUN) && armed && time_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pause <= 1'b1;
        end else begin
            state <= next_state;
            pause <= (next_state != S_RUN);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_edge) next_state = S_RUN;
            S_RUN: begin
                if (expiry)          next_state = (period < W'(NUM_PERIODS)) ? S_BREAK : S_FINAL;
                else if (pause_edge) next_state = S_PAUSED;
            end
            S_PAUSED: if (pause_edge || start_edge) next_state = S_RUN;
            S_BREAK:  if (start_edge) next_state = S_RUN;
            default:  next_state = state;
        endcase
    end

    // Scoring looks at the state before this cycle's transition.
    always_comb begin
        score_en      = (state == S_RUN) || (state == S_PAUSED) || (state == S_BREAK);
        cmd_h_next    = score_en ? pick(h_edge) : 6'b000000;
        cmd_g_next    = score_en ? pick(g_edge) : 6'b000000;
        enter_run     = (next_state == S_RUN) && (state != S_RUN);
        enter_buzz    = (next_state != state) &&
                        ((next_state == S_BREAK) || (next_state == S_FINAL));
        buzz_cnt_next = buzz_cnt;
        if (enter_buzz)             buzz_cnt_next = CW'(BUZZ_CYCLES);
        else if (buzz_cnt != '0)    buzz_cnt_next = buzz_cnt - CW'(1);
    end

    // armed blocks a stale 0:00 from expiring a freshly resumed period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_H    <= 6'b000000;
            cmd_G    <= 6'b000000;
            buzz_cnt <= '0;
            buzzer   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            cmd_H    <= cmd_h_next;
            cmd_G    <= cmd_g_next;
            buzz_cnt <= buzz_cnt_next;
            buzzer   <= (buzz_cnt_next != '0);
            if (enter_run)                        armed <= 1'b0;
            else if (state == S_RUN && !time_zero) armed <= 1'b1;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: expected command pulses are queued with their
// due cycle when buttons are driven and matched against the DUT every cycle.
module tb_scoreboard_ctrl;
    localparam int W  = 11;
    localparam int BC = 8;

    logic         clk;
    logic         reset;
    logic         start_btn, pause_btn;
    logic [5:0]   btn_H, btn_G;
    logic [W-1:0] min, sec, period;
    logic         pause;
    logic [5:0]   cmd_H, cmd_G;
    logic [2:0]   game_state;
    logic         buzzer;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [5:0] exp_h_q[$];
    logic [5:0] exp_g_q[$];
    int         exp_h_cyc_q[$];
    int         exp_g_cyc_q[$];

    scoreboard_ctrl #(.NUM_PERIODS(4), .BUZZ_CYCLES(BC), .W(W)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
        .btn_H(btn_H), .btn_G(btn_G), .min(min), .sec(sec), .period(period),
        .pause(pause), .cmd_H(cmd_H), .cmd_G(cmd_G), .game_state(game_state),
        .buzzer(buzzer)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A button edge driven now is sampled at the next edge and pulses after the one after.
    task automatic expect_h(input logic [5:0] v);
        exp_h_q.push_back(v);
        exp_h_cyc_q.push_back(cyc + 2);
    endtask

    task automatic expect_g(input logic [5:0] v);
        exp_g_q.push_back(v);
        exp_g_cyc_q.push_back(cyc + 2);
    endtask

    task automatic tick();
        int         c;
        logic [5:0] v;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_h_q.size() > 0 && exp_h_cyc_q[0] == cyc) begin
            v = exp_h_q.pop_front();
            c = exp_h_cyc_q.pop_front();
            chk("cmd_H", {26'd0, cmd_H}, {26'd0, v});
        end else if (cmd_H !== 6'b000000) begin
            chk("cmd_H_spurious", {26'd0, cmd_H}, 32'd0);
        end
        if (exp_g_q.size() > 0 && exp_g_cyc_q[0] == cyc) begin
            v = exp_g_q.pop_front();
            c = exp_g_cyc_q.pop_front();
            chk("cmd_G", {26'd0, cmd_G}, {26'd0, v});
        end else if (cmd_G !== 6'b000000) begin
            chk("cmd_G_spurious", {26'd0, cmd_G}, 32'd0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_buzz(input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (buzzer === 1'b1) hi++;
            tick();
        end
        chk(tag, hi, BC);
    endtask

    initial begin
        // reset with start and home plus1 held through it
        reset = 1'b1; start_btn = 1'b1; pause_btn = 1'b0;
        btn_H = 6'b000001; btn_G = 6'b000000;
        min = 11'd5; sec = 11'd0; period = 11'd1;
        ticks(3);
        chk("rst_state", game_state, 0);
        chk("rst_pause", pause, 1);
        chk("rst_buzzer", buzzer, 0);
        chk("rst_cmd_H", cmd_H, 0);
        chk("rst_cmd_G", cmd_G, 0);
        reset = 1'b0;
        ticks(4);
        chk("held_start_no_run", game_state, 0);
        start_btn = 1'b0; btn_H = 6'b000000;
        ticks(2);

        // IDLE: scoring disabled, pause ignored, start wins over pause
        btn_G = 6'b000100;
        ticks(3);
        btn_G = 6'b000000; pause_btn = 1'b1;
        ticks(2);
        chk("idle_pause_ignored", game_state, 0);
        pause_btn = 1'b0;
        tick();
        start_btn = 1'b1; pause_btn = 1'b1;
        ticks(2);
        chk("start_wins_state", game_state, 1);
        chk("start_wins_pause", pause, 0);
        tick();
        chk("run_stays", game_state, 1);
        start_btn = 1'b0; pause_btn = 1'b0;
        tick();

        // RUN: single pulse on press, no repeat while held
        btn_H = 6'b000001; expect_h(6'b000001);
        ticks(5);
        btn_H = 6'b000000;
        tick();

        // pause / resume paths
        pause_btn = 1'b1;
        ticks(2);
        chk("paused_state", game_state, 2);
        chk("paused_pause", pause, 1);
        pause_btn = 1'b0;
        btn_G = 6'b000010; expect_g(6'b000010);
        ticks(3);
        btn_G = 6'b000000;
        start_btn = 1'b1;
        ticks(2);
        chk("resume_start_state", game_state, 1);
        chk("resume_start_pause", pause, 0);
        start_btn = 1'b0;
        tick();
        pause_btn = 1'b1;
        ticks(2);
        chk("pause_again", game_state, 2);
        pause_btn = 1'b0;
        tick();
        pause_btn = 1'b1;
        ticks(2);
        chk("resume_pause_btn", game_state, 1);
        pause_btn = 1'b0;
        tick();

        // arbitration
        btn_H = 6'b100101; expect_h(6'b000100);
        btn_G = 6'b000010; expect_g(6'b000010);
        ticks(3);
        btn_H = 6'b000000; btn_G = 6'b000000;
        tick();
        btn_H = 6'b111000; expect_h(6'b001000);
        btn_G = 6'b110000; expect_g(6'b010000);
        ticks(3);
        btn_H = 6'b000000; btn_G = 6'b000000;
        tick();

        // period expiry -> BREAK with buzzer
        min = 11'd0; sec = 11'd1;
        tick();
        sec = 11'd0;
        tick();
        chk("break_state", game_state, 3);
        chk("break_pause", pause, 1);
        chk("break_buzzer", buzzer, 1);
        count_buzz("break_buzz_len");

        btn_H = 6'b000010; expect_h(6'b000010);
        ticks(3);
        btn_H = 6'b000000;

        // resume on stale 0:00 must not expire
        start_btn = 1'b1;
        ticks(2);
        chk("stale_run", game_state, 1);
        ticks(3);
        chk("stale_not_armed", game_state, 1);
        start_btn = 1'b0;
        min = 11'd10;
        tick();
        min = 11'd0;
        tick();
        chk("break_again", game_state, 3);
        chk("break_again_buzz", buzzer, 1);

        // final period: expiry beats simultaneous pause, reloads the buzzer
        period = 11'd4; sec = 11'd5; start_btn = 1'b1;
        ticks(2);
        chk("final_run", game_state, 1);
        start_btn = 1'b0;
        tick();
        pause_btn = 1'b1;
        btn_G = 6'b000001; expect_g(6'b000001);
        tick();
        sec = 11'd0;
        tick();
        chk("final_state", game_state, 4);
        chk("final_pause", pause, 1);
        chk("final_buzzer", buzzer, 1);
        pause_btn = 1'b0; btn_G = 6'b000000;
        count_buzz("final_buzz_reload_len");

        btn_H = 6'b000100; start_btn = 1'b1; pause_btn = 1'b1;
        ticks(3);
        chk("final_terminal", game_state, 4);
        btn_H = 6'b000000; start_btn = 1'b0; pause_btn = 1'b0;
        tick();

        // reset mid-buzz in FINAL
        reset = 1'b1;
        tick();
        reset = 1'b0; sec = 11'd1; start_btn = 1'b1;
        ticks(2);
        chk("rerun_state", game_state, 1);
        start_btn = 1'b0;
        tick();
        sec = 11'd0;
        tick();
        chk("refinal_state", game_state, 4);
        chk("refinal_buzz", buzzer, 1);
        ticks(2);
        reset = 1'b1;
        tick();
        chk("midbuzz_rst_buzzer", buzzer, 0);
        chk("midbuzz_rst_state", game_state, 0);
        chk("midbuzz_rst_pause", pause, 1);
        reset = 1'b0;
        tick();

        chk("exp_h_drained", exp_h_q.size(), 0);
        chk("exp_g_drained", exp_g_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
